// File: rtl/frankie_ctrl_pkg.sv
// frankie_ctrl_pkg: shared state, opcode and select encodings for the Frankie multicycle control
package frankie_ctrl_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT, S_ERROR} state_t;
  localparam logic [4:0] OP_ALU_LAST  = 5'h0D;
  localparam logic [4:0] OP_CMP_FIRST = 5'h0E;
  localparam logic [4:0] OP_CMP_LAST  = 5'h0F;
  localparam logic [4:0] OP_LOAD      = 5'h10;
  localparam logic [4:0] OP_STORE     = 5'h11;
  localparam logic [4:0] OP_BRANCH    = 5'h12;
  localparam logic [4:0] OP_JUMP      = 5'h13;
  localparam logic [4:0] OP_JAL       = 5'h14;
  localparam logic [4:0] OP_PUSH      = 5'h15;
  localparam logic [4:0] OP_POP       = 5'h16;
  localparam logic [4:0] OP_RET       = 5'h17;
  localparam logic [4:0] OP_HALT      = 5'h1F;
  localparam logic [1:0] MS_PC  = 2'd0;
  localparam logic [1:0] MS_ALU = 2'd1;
  localparam logic [1:0] MS_SP  = 2'd2;
  localparam logic [1:0] MS_SP1 = 2'd3;
  localparam logic [1:0] PS_INC = 2'd0;
  localparam logic [1:0] PS_BR  = 2'd1;
  localparam logic [1:0] PS_JMP = 2'd2;
  localparam logic [1:0] PS_RA  = 2'd3;
  function automatic logic is_mem_op(input logic [4:0] op);
    return op == OP_LOAD || op == OP_STORE || op == OP_PUSH || op == OP_POP;
  endfunction
  function automatic logic is_legal(input logic [4:0] op);
    return op <= OP_RET || op == OP_HALT;
  endfunction
endpackage

// File: rtl/frankie_mem_watchdog.sv
// frankie_mem_watchdog: counts memory wait cycles and flags a timeout
module frankie_mem_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  input  logic clear,
  output logic expired
);
  logic [7:0] cnt_q, cnt_d;
  // a completed handshake or a state change restarts the count
  always_comb cnt_d = (clear || ready) ? '0 : active ? cnt_q + 8'd1 : cnt_q;
  // wait counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign expired = active && !ready && cnt_q == 8'(TIMEOUT);
endmodule

// File: rtl/frankie_mc_control.sv
// frankie_mc_control: multicycle control sequencer; FRANKIE_PERF_CNT_EN adds cycle/retired counters
module frankie_mc_control
  import frankie_ctrl_pkg::*;
#(
  parameter int INST_W      = 16,
  parameter int OPCODE_W    = 5,
  parameter int OPCODE_LSB  = 10,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [INST_W-1:0] inst,
  input  logic              comp_true,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_write,
  output logic [1:0]        mem_src,
  output logic              inst_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              sp_write,
  output logic              sp_src,
  output logic              mary_write,
  output logic              comp_write,
  output logic              ra_write,
  output logic [3:0]        alu_op,
  output logic              src_b,
  output logic              halted,
  output logic              illegal,
  output logic              mem_error
`ifdef FRANKIE_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       retired_cnt
`endif
);
  state_t state_q, state_d;
  logic [4:0] op_q, op_d;
  logic flag_q, flag_d, bad_q, bad_d, illegal_q, illegal_d, mem_error_q, mem_error_d;
  logic expired, wd_active, wd_clear, flag_in, unused_inst;
  logic [OPCODE_W-1:0] op_raw;
  assign op_raw      = inst[OPCODE_LSB +: OPCODE_W];
  assign flag_in     = inst[OPCODE_LSB+OPCODE_W];
  assign unused_inst = ^inst;
  assign wd_active   = state_q == S_FETCH || state_q == S_MEM;
  assign wd_clear    = state_d != state_q;
  frankie_mem_watchdog #(.TIMEOUT(MEM_TIMEOUT)) u_wd (
    .clk(clock), .rst(reset), .active(wd_active), .ready(mem_ready), .clear(wd_clear), .expired(expired)
  );
  // next state; opcode is classified once in DECODE and held through EXEC/MEM
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    flag_d      = flag_q;
    bad_d       = bad_q;
    illegal_d   = illegal_q;
    mem_error_d = mem_error_q | expired;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : expired ? S_ERROR : S_FETCH;
      S_DECODE: begin
        op_d    = op_raw[4:0];
        flag_d  = flag_in;
        bad_d   = !is_legal(op_raw[4:0]) || (op_raw >> 5) != '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        illegal_d = illegal_q | bad_q;
        state_d   = (bad_q || op_q == OP_HALT) ? S_HALT : is_mem_op(op_q) ? S_MEM : S_FETCH;
      end
      S_MEM:    state_d = mem_ready ? S_FETCH : expired ? S_ERROR : S_MEM;
      default:  state_d = state_q;
    endcase
  end
  // sequencer state and sticky status
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_FETCH;
      op_q        <= '0;
      flag_q      <= 1'b0;
      bad_q       <= 1'b0;
      illegal_q   <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      flag_q      <= flag_d;
      bad_q       <= bad_d;
      illegal_q   <= illegal_d;
      mem_error_q <= mem_error_d;
    end
  end
  // datapath controls decoded from state; everything is held low while reset is asserted
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    mem_src    = MS_PC;
    inst_write = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PS_INC;
    sp_write   = 1'b0;
    sp_src     = 1'b0;
    mary_write = 1'b0;
    comp_write = 1'b0;
    ra_write   = 1'b0;
    alu_op     = '0;
    src_b      = 1'b0;
    halted     = 1'b0;
    illegal    = illegal_q & ~reset;
    mem_error  = mem_error_q & ~reset;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          inst_write = mem_ready;
          pc_write   = mem_ready;
        end
        S_EXEC: if (!bad_q) begin
          alu_op     = op_q <= OP_CMP_LAST ? op_q[3:0] : '0;
          src_b      = op_q <= OP_CMP_LAST ? flag_q : 1'b0;
          mary_write = op_q <= OP_ALU_LAST;
          comp_write = op_q >= OP_CMP_FIRST && op_q <= OP_CMP_LAST;
          ra_write   = op_q == OP_JAL;
          pc_src     = op_q == OP_BRANCH ? PS_BR : (op_q == OP_JUMP || op_q == OP_JAL) ? PS_JMP :
                       op_q == OP_RET ? PS_RA : PS_INC;
          pc_write   = (op_q == OP_BRANCH && comp_true) || op_q == OP_JUMP || op_q == OP_JAL || op_q == OP_RET;
        end
        S_MEM: begin
          mem_req    = 1'b1;
          mem_write  = op_q == OP_STORE || op_q == OP_PUSH;
          mem_src    = op_q == OP_PUSH ? MS_SP : op_q == OP_POP ? MS_SP1 : MS_ALU;
          mary_write = mem_ready && (op_q == OP_LOAD || op_q == OP_POP);
          sp_write   = mem_ready && (op_q == OP_PUSH || op_q == OP_POP);
          sp_src     = mem_ready && op_q == OP_POP;
        end
        S_HALT, S_ERROR: halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end
`ifdef FRANKIE_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d, retired_cnt_q, retired_cnt_d;
  // running cycles and instructions retired back into FETCH
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + ((state_q != S_HALT && state_q != S_ERROR) ? 32'd1 : 32'd0);
    retired_cnt_d = retired_cnt_q + ((state_d == S_FETCH && (state_q == S_EXEC || state_q == S_MEM)) ? 32'd1 : 32'd0);
  end
  // performance counter registers
  always_ff @(posedge clock) begin
    cycle_cnt_q   <= reset ? '0 : cycle_cnt_d;
    retired_cnt_q <= reset ? '0 : retired_cnt_d;
  end
  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
`endif
endmodule

// File: tb/tb_frankie_mc_control.sv
// tb_frankie_mc_control: scoreboard bench for the multicycle control sequencer
module tb_frankie_mc_control;
  logic clock = 1'b0, reset = 1'b1, comp_true = 1'b0, mem_ready = 1'b0;
  logic [15:0] inst = '0, cur_inst = '0;
  logic mem_req, mem_write, inst_write, pc_write, sp_write, sp_src, mary_write, comp_write, ra_write;
  logic src_b, halted, illegal, mem_error;
  logic [1:0] mem_src, pc_src;
  logic [3:0] alu_op;
  logic [20:0] got, want;
  string nm;
  string q_nm[$];
  logic [20:0] q_v[$];
  int total = 0, bad = 0;

  frankie_mc_control dut (
    .clock(clock), .reset(reset), .inst(inst), .comp_true(comp_true), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .mem_src(mem_src), .inst_write(inst_write),
    .pc_write(pc_write), .pc_src(pc_src), .sp_write(sp_write), .sp_src(sp_src),
    .mary_write(mary_write), .comp_write(comp_write), .ra_write(ra_write), .alu_op(alu_op),
    .src_b(src_b), .halted(halted), .illegal(illegal), .mem_error(mem_error)
  );

  always #5 clock = ~clock;

  function automatic logic [20:0] o(input logic mr, mw, input logic [1:0] ms, input logic iw, pw,
                                    input logic [1:0] ps, input logic sw, ss, maw, cw, rw,
                                    input logic [3:0] alu, input logic sb, h, il, me);
    return {mr, mw, ms, iw, pw, ps, sw, ss, maw, cw, rw, alu, sb, h, il, me};
  endfunction

  function automatic logic [15:0] ins(input logic [4:0] op, input logic flag);
    return {flag, op, 10'h000};
  endfunction

  function automatic logic [20:0] ft(input logic rdy);
    return o(1, 0, 0, rdy, rdy, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic step(input string s, input logic r, input logic rdy, input logic cmp, input logic [20:0] e);
    @(posedge clock);
    #1;
    reset = r;
    mem_ready = rdy;
    comp_true = cmp;
    inst = cur_inst;
    q_nm.push_back(s);
    q_v.push_back(e);
  endtask

  task automatic run3(input string s, input logic [4:0] op, input logic flag, input logic cmp, input logic [20:0] ex);
    cur_inst = ins(op, flag);
    step({s, "_fetch"}, 0, 1, cmp, ft(1));
    step({s, "_decode"}, 0, 1, cmp, '0);
    step({s, "_exec"}, 0, 1, cmp, ex);
  endtask

  always @(negedge clock) begin
    if (q_v.size() != 0) begin
      nm = q_nm.pop_front();
      want = q_v.pop_front();
      got = {mem_req, mem_write, mem_src, inst_write, pc_write, pc_src, sp_write, sp_src,
             mary_write, comp_write, ra_write, alu_op, src_b, halted, illegal, mem_error};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s got=%h want=%h", nm, got, want);
      end
    end
  end

  initial begin
    step("reset0", 1, 0, 0, '0);
    step("reset1", 1, 0, 0, '0);
    run3("alu03", 5'h03, 1, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'h3, 1, 0, 0, 0));
    run3("cmp0e", 5'h0E, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hE, 0, 0, 0, 0));
    run3("br_nt", 5'h12, 0, 0, o(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run3("br_t", 5'h12, 0, 1, o(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run3("jump", 5'h13, 0, 0, o(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run3("jal", 5'h14, 0, 0, o(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    run3("ret", 5'h17, 0, 0, o(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run3("load", 5'h10, 0, 0, '0);
    step("load_mem", 0, 1, 0, o(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    run3("store", 5'h11, 0, 0, '0);
    step("store_mem", 0, 1, 0, o(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run3("pop", 5'h16, 0, 0, '0);
    step("pop_mem", 0, 1, 0, o(1, 0, 3, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    run3("push", 5'h15, 0, 0, '0);
    for (int i = 0; i < 4; i++) step("push_wait", 0, 0, 0, o(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("push_done", 0, 1, 0, o(1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) step("to_wait", 0, 0, 0, ft(0));
    step("to_error", 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    step("to_stuck", 0, 1, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    step("to_reset", 1, 0, 0, '0);
    cur_inst = ins(5'h1F, 0);
    for (int i = 0; i < 15; i++) step("edge_wait", 0, 0, 0, ft(0));
    step("edge_ready", 0, 1, 0, ft(1));
    step("halt_decode", 0, 1, 0, '0);
    step("halt_exec", 0, 1, 0, '0);
    step("halt0", 0, 1, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step("halt1", 0, 1, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step("halt_reset", 1, 1, 0, '0);
    run3("ill18", 5'h18, 0, 0, '0);
    for (int i = 0; i < 3; i++) step("ill_halt", 0, 1, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    step("ill_reset", 1, 1, 0, '0);
    run3("ldstall", 5'h10, 0, 0, '0);
    step("ldstall_mem", 0, 0, 0, o(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("mid_mem_reset", 1, 0, 0, '0);
    cur_inst = ins(5'h03, 0);
    step("post_reset_fetch", 0, 1, 0, ft(1));
    step("post_reset_decode", 0, 1, 0, '0);
    for (int i = 0; i < 10 && q_v.size() != 0; i++) @(posedge clock);
    if (q_v.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q_v.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frankie_mc_control.md
Name: frankie_mc_control

Overview:
- Parametrised multicycle control sequencer for the Frankie core; successor to the single-decode control unit.
- Sits between the instruction register and the datapath. It drives every datapath write-enable and mux select.
- Adds a variable-latency memory handshake (req/ready), a memory timeout watchdog, a sticky HALT state and illegal-opcode trapping.

Parameters:
INST_W, 16, instruction width in bits
OPCODE_W, 5, opcode field width
OPCODE_LSB, 10, bit position of opcode LSB; flag bit is inst[OPCODE_LSB+OPCODE_W]
MEM_TIMEOUT, 15, max wait cycles for mem_ready before error (1..255)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
inst  in  INST_W  current instruction register contents
comp_true  in  1  comparison register nonzero (branch condition)
mem_ready  in  1  memory completes the outstanding request this cycle
mem_req  out  1  memory access request, held until mem_ready
mem_write  out  1  request is a write
mem_src  out  2  address select: 0=PC, 1=ALU result, 2=SP, 3=SP+1
inst_write  out  1  load instruction register
pc_write  out  1  PC update enable
pc_src  out  2  0=PC+1, 1=branch target, 2=jump target, 3=RA
sp_write  out  1  SP update enable
sp_src  out  1  0=SP-1 (push), 1=SP+1 (pop)
mary_write  out  1  mary register write enable
comp_write  out  1  comp register write enable
ra_write  out  1  RA write enable (RA <= PC)
alu_op  out  4  ALU operation
src_b  out  1  ALU B operand: 0=shelley, 1=immediate
halted  out  1  sticky halt status
illegal  out  1  sticky illegal-opcode status
mem_error  out  1  sticky memory-timeout status

Behaviour:
- Reset: state=FETCH, wait counter=0, all outputs 0, including sticky flags. Reset is honoured in any state, including mid-handshake, and drops mem_req the same edge.
- States: FETCH, DECODE, EXEC, MEM, HALT, ERROR.
- FETCH:
  - mem_req=1, mem_src=0.
  - On mem_ready, same cycle: inst_write=1, pc_write=1, pc_src=0.
  - Then go to DECODE.
- DECODE: one cycle, no enables asserted; classifies the opcode.
- EXEC, per opcode, then FETCH unless noted:
  - 0x00–0x0D: alu_op=opcode[3:0], src_b=flag bit, mary_write=1.
  - 0x0E–0x0F: compare; alu_op=opcode[3:0], src_b=flag, comp_write=1.
  - 0x12 BRANCH: pc_src=1, pc_write=comp_true.
  - 0x13 JUMP: pc_src=2, pc_write=1.
  - 0x14 JAL: ra_write=1, pc_src=2, pc_write=1.
  - 0x17 RET: pc_src=3, pc_write=1.
  - 0x10 LOAD, 0x11 STORE, 0x15 PUSH, 0x16 POP: go to MEM.
  - 0x1F: go to HALT.
  - Any other opcode: illegal<=1, go to HALT.
- MEM:
  - mem_req=1.
  - Address and direction by opcode:
    - LOAD: mem_src=1, read.
    - STORE: mem_src=1, mem_write=1.
    - PUSH: mem_src=2, mem_write=1.
    - POP: mem_src=3, read.
  - On mem_ready:
    - LOAD/POP: mary_write=1.
    - PUSH: sp_write=1, sp_src=0.
    - POP: sp_write=1, sp_src=1.
    - Then go to FETCH.
  - mem_write and mem_src must hold stable while mem_req is high.
- Timeout:
  - The wait counter increments on each FETCH/MEM cycle without mem_ready.
  - When it reaches MEM_TIMEOUT: mem_error<=1, go to ERROR, drop mem_req.
  - The counter clears on mem_ready and on every state entry.
  - mem_ready on the same cycle the count hits MEM_TIMEOUT wins: completes normally, no error.
- HALT/ERROR: terminal until reset; all enables 0; halted=1 in both.
- Latency with zero-wait memory (mem_ready tied high): ALU/branch/jump instructions 3 cycles; memory instructions 4 cycles. Each wait cycle adds 1.
- Opcode fields wider than 5 bits (OPCODE_W>5): upper bits must be zero, otherwise illegal.

Optional Feature:
FRANKIE_PERF_CNT_EN:
- Enabled:
  - Adds outputs cycle_cnt[31:0] (increments every cycle not in HALT/ERROR) and retired_cnt[31:0] (increments on each transition back into FETCH from EXEC or MEM).
  - Both counters wrap modulo 2^32 and clear on reset.
- Disabled: ports absent, no counter logic.

Decomposition:
- Package frankie_ctrl_pkg holds:
  - state enum;
  - opcode constants (OP_LOAD=0x10 … OP_HALT=0x1F);
  - mem_src and pc_src encodings;
  - ALU/compare opcode range bounds.
- One sub-module: frankie_mem_watchdog, the wait counter plus timeout compare (inputs: active, ready, clear; output: expired).

Test Plan:
- Reset mid-MEM with mem_req=1 → next cycle mem_req=0, state FETCH, halted/illegal/mem_error=0.
- ALU op 0x03 with flag=1, mem_ready tied high → inst_write cycle 0, mary_write=1 with src_b=1, alu_op=3 in cycle 2; next fetch starts cycle 3.
- BRANCH 0x12: comp_true=0 → pc_write=0 in EXEC; comp_true=1 → pc_write=1, pc_src=1.
- PUSH with mem_ready delayed 4 cycles → mem_req, mem_write=1, mem_src=2 held 5 cycles; sp_write=1, sp_src=0 only on the ready cycle.
- MEM_TIMEOUT=15, mem_ready held low in FETCH → mem_error=1 after 15 wait cycles, mem_req=0. Repeat with ready asserted on cycle 15 → no error.
- Opcode 0x18 → illegal=1, halted=1, no further inst_write until reset. Opcode 0x1F → halted=1, illegal=0.
